// File: rtl/output_queue_demux_pkg.sv
// output_queue_demux_pkg: shared definitions for the output queue demux.
//   state_t   - packet steering FSM encoding (HEAD, FWD, DROP)
//   C_DST_POS_DEF - default LSB of the one-hot destination field in tuser
//   pri_enc() - one-hot (4-bit) to index, lowest set bit wins, plus valid flag
package output_queue_demux_pkg;

  typedef enum logic [1:0] {
    HEAD = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam int C_DST_POS_DEF = 24;

  typedef struct packed {
    logic       vld;
    logic [1:0] idx;
  } penc_t;

  // Lowest set bit wins: multicast destinations collapse to one queue.
  function automatic penc_t pri_enc(input logic [3:0] oh);
    penc_t r;
    r.vld = |oh;
    r.idx = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (oh[i]) r.idx = 2'(i);
    return r;
  endfunction

endpackage

// File: rtl/output_queue_demux_stats.sv
// output_queue_demux_stats: per-queue forwarded-packet counters and a drop
// counter, all 32-bit and wrapping.
//   axis_clk, reset      - clock, async active-high reset
//   pkt_inc[q]           - a tlast beat drained to queue q this cycle
//   drop_inc             - a tlast beat of a dropped packet was accepted
//   pkt_cnt[q], drop_cnt - counter values
module output_queue_demux_stats (
  input  logic             axis_clk,
  input  logic             reset,
  input  logic [3:0]       pkt_inc,
  input  logic             drop_inc,
  output logic [3:0][31:0] pkt_cnt,
  output logic [31:0]      drop_cnt
);

  always_ff @(posedge axis_clk or posedge reset) begin
    if (reset) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      for (int q = 0; q < 4; q++)
        if (pkt_inc[q]) pkt_cnt[q] <= pkt_cnt[q] + 32'd1;
      if (drop_inc) drop_cnt <= drop_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/output_queue_demux.sv
// output_queue_demux: steers each packet of one AXI4-Stream to one of four
// queue streams, chosen by the one-hot field tuser[C_DST_POS +: 4] on the
// first beat (lowest set bit wins). Packets with an empty field are dropped.
// One register slice sits on the output; all queues share its data buses and
// only the selected queue sees tvalid.
//   axis_clk, reset        - clock, async active-high reset
//   s_axis_*               - input stream
//   m_axis_*_0..3          - queue output streams
//   pkt_cnt_0..3, drop_cnt - statistics
// Macro OUTPUT_QUEUE_DEMUX_STATS_EN enables the counters; when undefined
// they read as zero.
module output_queue_demux
  import output_queue_demux_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_QUEUES       = 4,
  parameter int C_NUM_QUEUES_WIDTH = 2,
  parameter int C_DST_POS          = C_DST_POS_DEF
) (
  input  logic                            axis_clk,
  input  logic                            reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tlast,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_0,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep_0,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_0,
  output logic                            m_axis_tlast_0,
  output logic                            m_axis_tvalid_0,
  input  logic                            m_axis_tready_0,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_1,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep_1,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_1,
  output logic                            m_axis_tlast_1,
  output logic                            m_axis_tvalid_1,
  input  logic                            m_axis_tready_1,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_2,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep_2,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_2,
  output logic                            m_axis_tlast_2,
  output logic                            m_axis_tvalid_2,
  input  logic                            m_axis_tready_2,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_3,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep_3,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_3,
  output logic                            m_axis_tlast_3,
  output logic                            m_axis_tvalid_3,
  input  logic                            m_axis_tready_3,
  output logic [31:0]                     pkt_cnt_0,
  output logic [31:0]                     pkt_cnt_1,
  output logic [31:0]                     pkt_cnt_2,
  output logic [31:0]                     pkt_cnt_3,
  output logic [31:0]                     drop_cnt
);

  state_t                          state;
  logic [C_NUM_QUEUES_WIDTH-1:0]   sel, qsel;
  logic                            rdy_en;
  logic                            out_valid, out_last;
  logic [C_AXIS_DATA_WIDTH-1:0]    out_data;
  logic [C_AXIS_DATA_WIDTH/8-1:0]  out_keep;
  logic [C_AXIS_TUSER_WIDTH-1:0]   out_user;

  logic [3:0] m_rdy, dst;
  penc_t      enc;
  logic       accept, load, drain;

  assign m_rdy = {m_axis_tready_3, m_axis_tready_2, m_axis_tready_1, m_axis_tready_0};
  assign dst   = s_axis_tuser[C_DST_POS +: C_NUM_QUEUES];
  assign enc   = pri_enc(dst);

  // rdy_en holds tready low through reset and for the first edge after it.
  // DROP never touches the output slice, so it can always accept.
  assign s_axis_tready = rdy_en & ((state == DROP) | ~out_valid | m_rdy[qsel]);
  assign accept = s_axis_tvalid & s_axis_tready;
  assign load   = accept & ((state == FWD) | ((state == HEAD) & enc.vld));
  assign drain  = out_valid & m_rdy[qsel];

  always_ff @(posedge axis_clk or posedge reset) begin
    if (reset) begin
      state  <= HEAD;
      sel    <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (accept) begin
        case (state)
          HEAD: begin
            if (enc.vld) begin
              sel <= enc.idx;
              if (!s_axis_tlast) state <= FWD;
            end else if (!s_axis_tlast) begin
              state <= DROP;
            end
          end
          FWD:     if (s_axis_tlast) state <= HEAD;
          DROP:    if (s_axis_tlast) state <= HEAD;
          default: state <= HEAD;
        endcase
      end
    end
  end

  // Output register slice; load wins over drain so a new beat can replace
  // the draining one in the same cycle.
  always_ff @(posedge axis_clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_user  <= '0;
      qsel      <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_last  <= s_axis_tlast;
      out_data  <= s_axis_tdata;
      out_keep  <= s_axis_tkeep;
      out_user  <= s_axis_tuser;
      qsel      <= (state == HEAD) ? enc.idx : sel;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

  assign m_axis_tdata_0 = out_data;  assign m_axis_tkeep_0 = out_keep;
  assign m_axis_tuser_0 = out_user;  assign m_axis_tlast_0 = out_last;
  assign m_axis_tdata_1 = out_data;  assign m_axis_tkeep_1 = out_keep;
  assign m_axis_tuser_1 = out_user;  assign m_axis_tlast_1 = out_last;
  assign m_axis_tdata_2 = out_data;  assign m_axis_tkeep_2 = out_keep;
  assign m_axis_tuser_2 = out_user;  assign m_axis_tlast_2 = out_last;
  assign m_axis_tdata_3 = out_data;  assign m_axis_tkeep_3 = out_keep;
  assign m_axis_tuser_3 = out_user;  assign m_axis_tlast_3 = out_last;

  assign m_axis_tvalid_0 = out_valid & (qsel == 2'd0);
  assign m_axis_tvalid_1 = out_valid & (qsel == 2'd1);
  assign m_axis_tvalid_2 = out_valid & (qsel == 2'd2);
  assign m_axis_tvalid_3 = out_valid & (qsel == 2'd3);

`ifdef OUTPUT_QUEUE_DEMUX_STATS_EN
  logic [3:0]       pkt_inc;
  logic             drop_inc;
  logic [3:0][31:0] pkt_cnt;

  always_comb begin
    pkt_inc = '0;
    for (int q = 0; q < 4; q++)
      pkt_inc[q] = drain & out_last & (qsel == C_NUM_QUEUES_WIDTH'(q));
  end

  assign drop_inc = accept & s_axis_tlast &
                    ((state == DROP) | ((state == HEAD) & ~enc.vld));

  output_queue_demux_stats u_stats (
    .axis_clk (axis_clk),
    .reset    (reset),
    .pkt_inc  (pkt_inc),
    .drop_inc (drop_inc),
    .pkt_cnt  (pkt_cnt),
    .drop_cnt (drop_cnt)
  );

  assign pkt_cnt_0 = pkt_cnt[0];
  assign pkt_cnt_1 = pkt_cnt[1];
  assign pkt_cnt_2 = pkt_cnt[2];
  assign pkt_cnt_3 = pkt_cnt[3];
`else
  assign pkt_cnt_0 = 32'd0;
  assign pkt_cnt_1 = 32'd0;
  assign pkt_cnt_2 = 32'd0;
  assign pkt_cnt_3 = 32'd0;
  assign drop_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_output_queue_demux.sv
// tb_output_queue_demux: directed checks of steering, dropping, backpressure,
// full-rate switching and mid-packet reset. Counter expectations scale with
// OUTPUT_QUEUE_DEMUX_STATS_EN (zero when the counters are compiled out).
module tb_output_queue_demux;

`ifdef OUTPUT_QUEUE_DEMUX_STATS_EN
  localparam int ST = 1;
`else
  localparam int ST = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] s_data = '0;
  logic [31:0]  s_keep = '0;
  logic [127:0] s_user = '0;
  logic         s_last = 1'b0, s_valid = 1'b0;
  logic         s_ready;
  logic [255:0] d0, d1, d2, d3;
  logic [31:0]  k0, k1, k2, k3;
  logic [127:0] u0, u1, u2, u3;
  logic         l0, l1, l2, l3;
  logic         v0, v1, v2, v3;
  logic [3:0]   mrdy = 4'hF;
  logic [31:0]  pc0, pc1, pc2, pc3, dc;
  logic [3:0]   mv;

  int cmp_n = 0;
  int err_n = 0;

  always #5 clk = ~clk;
  assign mv = {v3, v2, v1, v0};

  output_queue_demux dut (
    .axis_clk(clk), .reset(rst),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tuser(s_user),
    .s_axis_tlast(s_last), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
    .m_axis_tdata_0(d0), .m_axis_tkeep_0(k0), .m_axis_tuser_0(u0),
    .m_axis_tlast_0(l0), .m_axis_tvalid_0(v0), .m_axis_tready_0(mrdy[0]),
    .m_axis_tdata_1(d1), .m_axis_tkeep_1(k1), .m_axis_tuser_1(u1),
    .m_axis_tlast_1(l1), .m_axis_tvalid_1(v1), .m_axis_tready_1(mrdy[1]),
    .m_axis_tdata_2(d2), .m_axis_tkeep_2(k2), .m_axis_tuser_2(u2),
    .m_axis_tlast_2(l2), .m_axis_tvalid_2(v2), .m_axis_tready_2(mrdy[2]),
    .m_axis_tdata_3(d3), .m_axis_tkeep_3(k3), .m_axis_tuser_3(u3),
    .m_axis_tlast_3(l3), .m_axis_tvalid_3(v3), .m_axis_tready_3(mrdy[3]),
    .pkt_cnt_0(pc0), .pkt_cnt_1(pc1), .pkt_cnt_2(pc2), .pkt_cnt_3(pc3),
    .drop_cnt(dc)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    cmp_n++;
    assert (obs === exp) else begin
      err_n++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one beat at a falling edge; #1 lets tready settle for a check.
  task automatic drive(input logic [255:0] data, input logic [3:0] dst, input logic last);
    s_valid = 1'b1;
    s_data  = data;
    s_keep  = 32'hFFFF_0000 | 32'(data[7:0]);
    s_user  = 128'hA5 | (128'(dst) << 24);
    s_last  = last;
    #1;
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_last  = 1'b0;
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_tready", 256'(s_ready), 256'd0);
    chk("rst_tvalid", 256'(mv), 256'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_cnt", 256'(pc0 | pc1 | pc2 | pc3 | dc), 256'd0);
    @(negedge clk);
    chk("ready_after_rst", 256'(s_ready), 256'd1);

    // 1) Three-beat packet to queue 2
    drive(256'h11, 4'b0100, 1'b0);
    chk("q2_ready", 256'(s_ready), 256'd1);
    @(negedge clk);
    chk("q2_b1_vld", 256'(mv), 256'b0100);
    chk("q2_b1_data", d2, 256'h11);
    chk("q2_b1_last", 256'(l2), 256'd0);
    chk("q2_b1_user", 256'(u2), 256'(128'hA5 | (128'h4 << 24)));
    chk("q2_b1_keep", 256'(k2), 256'h FFFF_0011);
    drive(256'h12, 4'b0001, 1'b0);  // non-first dst ignored
    @(negedge clk);
    chk("q2_b2_vld", 256'(mv), 256'b0100);
    chk("q2_b2_data", d2, 256'h12);
    drive(256'h13, 4'b0000, 1'b1);
    @(negedge clk);
    chk("q2_b3_vld", 256'(mv), 256'b0100);
    chk("q2_b3_data", d2, 256'h13);
    chk("q2_b3_last", 256'(l2), 256'd1);
    idle();
    @(negedge clk);
    chk("q2_drained", 256'(mv), 256'd0);
    chk("q2_pkt_cnt", 256'(pc2), 256'(ST));

    // 2) Multicast field resolves to lowest bit
    drive(256'h21, 4'b0110, 1'b1);
    @(negedge clk);
    chk("lsb_vld", 256'(mv), 256'b0010);
    chk("lsb_data", d1, 256'h21);
    idle();
    @(negedge clk);
    chk("lsb_pkt_cnt1", 256'(pc1), 256'(ST));
    chk("lsb_pkt_cnt2", 256'(pc2), 256'(ST));

    // 3) Two-beat dropped packet, then one beat to queue 0
    drive(256'h31, 4'b0000, 1'b0);
    chk("drop_ready1", 256'(s_ready), 256'd1);
    @(negedge clk);
    chk("drop_vld1", 256'(mv), 256'd0);
    mrdy = 4'h0;
    drive(256'h32, 4'b0001, 1'b1);
    chk("drop_ready2", 256'(s_ready), 256'd1);
    @(negedge clk);
    chk("drop_vld2", 256'(mv), 256'd0);
    chk("drop_cnt", 256'(dc), 256'(ST));
    mrdy = 4'hF;
    drive(256'h33, 4'b0001, 1'b1);
    @(negedge clk);
    chk("q0_vld", 256'(mv), 256'b0001);
    chk("q0_data", d0, 256'h33);
    idle();
    @(negedge clk);
    chk("q0_pkt_cnt", 256'(pc0), 256'(ST));
    chk("drop_cnt_hold", 256'(dc), 256'(ST));

    // 4) Queue 3 stalled mid-packet
    drive(256'h41, 4'b1000, 1'b0);
    @(negedge clk);
    chk("stall_b1_vld", 256'(mv), 256'b1000);
    mrdy[3] = 1'b0;
    drive(256'h42, 4'b1000, 1'b0);
    chk("stall_ready", 256'(s_ready), 256'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_hold_vld", 256'(mv), 256'b1000);
      chk("stall_hold_data", d3, 256'h41);
      chk("stall_hold_ready", 256'(s_ready), 256'd0);
    end
    mrdy[3] = 1'b1;
    #1;
    chk("stall_release", 256'(s_ready), 256'd1);
    @(negedge clk);
    chk("stall_b2_data", d3, 256'h42);
    drive(256'h43, 4'b0000, 1'b1);
    @(negedge clk);
    chk("stall_b3_data", d3, 256'h43);
    chk("stall_b3_last", 256'(l3), 256'd1);
    idle();
    @(negedge clk);
    chk("stall_drained", 256'(mv), 256'd0);
    chk("q3_pkt_cnt", 256'(pc3), 256'(ST));

    // 5) One-beat packets to queues 0..3 at full rate
    for (int q = 0; q < 4; q++) begin
      drive(256'(8'h50 + q), 4'(1 << q), 1'b1);
      chk("rr_ready", 256'(s_ready), 256'd1);
      @(negedge clk);
      chk("rr_vld", 256'(mv), 256'(1 << q));
      chk("rr_data", d0, 256'(8'h50 + q));
    end
    idle();
    @(negedge clk);
    chk("rr_drained", 256'(mv), 256'd0);
    chk("rr_cnt0", 256'(pc0), 256'(2 * ST));
    chk("rr_cnt1", 256'(pc1), 256'(2 * ST));
    chk("rr_cnt2", 256'(pc2), 256'(2 * ST));
    chk("rr_cnt3", 256'(pc3), 256'(2 * ST));

    // 6) Reset during a four-beat packet
    drive(256'h61, 4'b0010, 1'b0);
    @(negedge clk);
    chk("mid_b1_vld", 256'(mv), 256'b0010);
    rst = 1'b1;
    idle();
    chk("mid_rst_vld", 256'(mv), 256'd0);
    chk("mid_rst_cnt", 256'(pc0 | pc1 | pc2 | pc3 | dc), 256'd0);
    chk("mid_rst_ready", 256'(s_ready), 256'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 256'(s_ready), 256'd1);
    drive(256'h71, 4'b0100, 1'b1);
    @(negedge clk);
    chk("post_rst_vld", 256'(mv), 256'b0100);
    chk("post_rst_data", d2, 256'h71);
    idle();
    @(negedge clk);
    chk("post_rst_cnt2", 256'(pc2), 256'(ST));
    chk("post_rst_cnt1", 256'(pc1), 256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
